// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: eight-digit multiplexed 7-segment scanner with a pending/shadow double buffer.
// Define LZ_BLANK_EN to blank leading-zero digits (digit 0 always follows its mask bit).
module seg_scan_ctrl #(
   parameter int SCAN_DIV = 20000,
   parameter int GAP_CYC  = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_in,
   input  logic [7:0]  mask_in,
   input  logic        load,
   output logic        ready,
   output logic [7:0]  led_en,
   output logic [7:0]  led,
   output logic        frame_done
);
   localparam int SW = $clog2(SCAN_DIV);
   typedef enum logic {GAP, ON} state_t;
   localparam state_t S_SLOT0 = (GAP_CYC > 0) ? GAP : ON;
   state_t        r_state;
   logic [SW-1:0] r_slot;
   logic [2:0]    r_digit;
   logic [31:0]   r_pend_data;
   logic [31:0]   r_data_sh;
   logic [7:0]    r_pend_mask;
   logic [7:0]    r_mask_sh;
   logic          r_full;
   logic          w_slot_end;
   logic          w_boundary;
   logic          w_accept;
   logic          w_lit;
   logic [7:0]    w_vis;
   logic [3:0]    w_nib;
   logic [6:0]    w_seg;
   assign w_slot_end = int'(r_slot) == SCAN_DIV - 1;
   assign w_boundary = w_slot_end && r_digit == 3'd7;
   assign w_accept   = load && ready;
   assign w_nib      = r_data_sh[{r_digit, 2'b00} +: 4];
   assign w_lit      = r_state == ON && w_vis[r_digit];
`ifdef LZ_BLANK_EN
   // a digit above 0 lights only if it or some higher nibble is nonzero
   always_comb begin
      w_vis = r_mask_sh;
      for (int i = 1; i < 8; i++)
         w_vis[i] = r_mask_sh[i] && (r_data_sh >> (4 * i)) != 32'd0;
   end
`else
   assign w_vis = r_mask_sh;
`endif
   always_comb begin
      case (w_nib)
         4'h0: w_seg = 7'h40;
         4'h1: w_seg = 7'h79;
         4'h2: w_seg = 7'h24;
         4'h3: w_seg = 7'h30;
         4'h4: w_seg = 7'h19;
         4'h5: w_seg = 7'h12;
         4'h6: w_seg = 7'h02;
         4'h7: w_seg = 7'h78;
         4'h8: w_seg = 7'h00;
         4'h9: w_seg = 7'h10;
         4'hA: w_seg = 7'h08;
         4'hB: w_seg = 7'h03;
         4'hC: w_seg = 7'h46;
         4'hD: w_seg = 7'h21;
         4'hE: w_seg = 7'h06;
         default: w_seg = 7'h0E;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_SLOT0;
         r_slot      <= '0;
         r_digit     <= 3'd0;
         r_pend_data <= 32'd0;
         r_pend_mask <= 8'd0;
         r_data_sh   <= 32'd0;
         r_mask_sh   <= 8'd0;
         r_full      <= 1'b0;
         ready       <= 1'b1;
         led_en      <= 8'hFF;
         led         <= 8'hFF;
         frame_done  <= 1'b0;
      end else begin
         r_slot     <= w_slot_end ? '0 : r_slot + 1'b1;
         r_digit    <= w_slot_end ? r_digit + 3'd1 : r_digit;
         r_state    <= w_slot_end ? S_SLOT0 : (int'(r_slot) == GAP_CYC - 1) ? ON : r_state;
         led_en     <= w_lit ? ~(8'd1 << r_digit) : 8'hFF;
         led        <= w_lit ? {1'b1, w_seg} : 8'hFF;
         frame_done <= w_boundary;
         // acceptance needs ready (= !full), so it never coincides with a transfer
         if (w_accept) begin
            r_pend_data <= data_in;
            r_pend_mask <= mask_in;
            r_full      <= 1'b1;
            ready       <= 1'b0;
         end else if (w_boundary && r_full) begin
            r_data_sh <= r_pend_data;
            r_mask_sh <= r_pend_mask;
            r_full    <= 1'b0;
            ready     <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized scoreboard bench; a cycle-count model predicts every output cycle.
module tb_seg_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load = 1'b0;
   logic [31:0] data_in = 32'd0;
   logic [7:0]  mask_in = 8'd0;
   logic        ready;
   logic [7:0]  led_en;
   logic [7:0]  led;
   logic        frame_done;
   int checks = 0;
   int failures = 0;
   int step = 0;
   typedef struct packed {
      logic [7:0] en;
      logic [7:0] seg;
      logic       fd;
      logic       rdy;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;
   logic [7:0] hex_tab [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                                8'h00, 8'h10, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E};

   seg_scan_ctrl #(.SCAN_DIV(8), .GAP_CYC(2)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .mask_in(mask_in), .load(load),
      .ready(ready), .led_en(led_en), .led(led), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%h want=%h", name, step, act, exp);
      end
   endfunction

   function automatic logic lz_ok(input logic [31:0] dv, input int d);
`ifdef LZ_BLANK_EN
      return d == 0 || (dv >> (4 * d)) != 32'd0;
`else
      return d >= 0 && dv !== 32'hx;
`endif
   endfunction

   // Reference: position in the frame follows purely from cycles since reset release.
   initial begin : model
      int k, s, d;
      logic mf, mr, vis;
      logic [31:0] pd, sd;
      logic [7:0] pm, sm;
      exp_t e;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            q.delete();
            k = 0; mf = 0; mr = 1; pd = 0; sd = 0; pm = 0; sm = 0;
         end else begin
            s = k % 8;
            d = (k / 8) % 8;
            vis = sm[d] && lz_ok(sd, d) && s >= 2;
            e.en  = vis ? ~(8'd1 << d) : 8'hFF;
            e.seg = vis ? (8'h80 | hex_tab[4'(sd >> (4 * d))]) : 8'hFF;
            e.fd  = (k % 64 == 63);
            if (k % 64 == 63 && mf) begin
               sd = pd; sm = pm; mf = 0;
            end
            if (load && mr) begin
               pd = data_in; pm = mask_in; mf = 1;
            end
            mr = !mf;
            e.rdy = mr;
            q.push_back(e);
            k++;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_led_en", led_en, 8'hFF);
         chk("rst_led", led, 8'hFF);
         chk("rst_frame_done", frame_done, 0);
         chk("rst_ready", ready, 1);
      end else if (q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL no_expected step=%0d got=%h want=queued", step, led_en);
      end else begin
         mon_e = q.pop_front();
         chk("led_en", led_en, mon_e.en);
         chk("led", led, mon_e.seg);
         chk("frame_done", frame_done, mon_e.fd);
         chk("ready", ready, mon_e.rdy);
         chk("one_digit", $countones(~led_en) <= 1, 1);
      end
   end

   task automatic drive(input logic ld, input logic [31:0] d, input logic [7:0] m);
      load = ld; data_in = d; mask_in = m;
      @(negedge clk); #1;
      step++;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, $urandom, 8'($urandom));
   endtask

   task automatic run_to(input int s);
      while (step < s) drive(1'b0, $urandom, 8'($urandom));
   endtask

   task automatic do_reset();
      load = 1'b0; rst = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst = 1'b1; step = 0;
   endtask

   initial begin
      do_reset();
      idle(3 * 64);
      do_reset();
      drive(1'b0, 32'd0, 8'd0);
      drive(1'b1, 32'h12345678, 8'hFF);
      drive(1'b1, 32'hDEADBEEF, 8'h0F);
      run_to(127);
      drive(1'b1, 32'hFFFFFFFF, 8'hFF);
      idle(3 * 64);
      drive(1'b1, 32'h000000A0, 8'hFF);
      idle(2 * 64);
      drive(1'b1, $urandom, 8'h81);
      idle(3 * 64);
      drive(1'b1, 32'h12345678, 8'hFF);
      run_to(740);
      rst = 1'b0;
      #1;
      chk("async_led_en", led_en, 8'hFF);
      chk("async_led", led, 8'hFF);
      chk("async_ready", ready, 1);
      @(negedge clk); #1;
      rst = 1'b1; step = 0;
      idle(2 * 64);
      repeat (640) drive($urandom_range(0, 7) == 0, $urandom,
                         $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
